data_ram_arbiter: RTL and testbench

Two-port arbiter that shares the single-access-per-cycle data RAM (256 x 16, synchronous write, combinational read) between the CPU memory stage (port 0) and the debug/program loader (port 1). It grants at most one access per cycle, drives the RAM read/write strobes, address and write data, and registers returned read data back to the winning port. A per-port lock lets one requester hold the RAM for a read-modify-write sequence.

---
 rtl/dram_arb_pkg.sv | 18 +
 rtl/dram_arb_pick.sv | 26 ++
 rtl/data_ram_arbiter.sv | 146 ++++++++++++++
 tb/tb_data_ram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared state codes, port indices and default sizes
// for the data RAM arbiter.
package dram_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t LOCK0 = 2'd1;
    localparam state_t LOCK1 = 2'd2;

    localparam int P0 = 0;
    localparam int P1 = 1;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 16;
    localparam int LOCK_MAX_DEF = 15;

endpackage

// File: rtl/dram_arb_pick.sv
// dram_arb_pick: combinational two-way picker, one-hot grant.
// With rr_en, a tie goes to the port not granted last.
module dram_arb_pick
    import dram_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    input  logic       rr_en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        unique case (1'b1)
            (req0 && req1): begin
                if (rr_en && !last) gnt[P1] = 1'b1;
                else                gnt[P0] = 1'b1;
            end
            (req0 && !req1): gnt[P0] = 1'b1;
            (req1 && !req0): gnt[P1] = 1'b1;
            default:         gnt = '0;
        endcase
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares one data RAM between CPU (port 0) and loader (port 1).
// Define DRAM_ARB_RR_EN for round-robin ties; default is fixed priority.
module data_ram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_p0_req,
    input  logic              i_p0_we,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [DATA_W-1:0] i_p0_wdata,
    input  logic              i_p0_lock,
    output logic              o_p0_gnt,
    output logic              o_p0_rvalid,
    output logic [DATA_W-1:0] o_p0_rdata,
    input  logic              i_p1_req,
    input  logic              i_p1_we,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [DATA_W-1:0] i_p1_wdata,
    input  logic              i_p1_lock,
    output logic              o_p1_gnt,
    output logic              o_p1_rvalid,
    output logic [DATA_W-1:0] o_p1_rdata,
    output logic              o_lock_err,
    output logic              o_ram_write,
    output logic [ADDR_W-1:0] o_ram_addr_write,
    output logic [DATA_W-1:0] o_ram_data_write,
    output logic              o_ram_read,
    output logic [ADDR_W-1:0] o_ram_addr_read,
    input  logic [DATA_W-1:0] i_ram_data_read
);

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_MAX - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              last;
    logic              rr_en;
    logic              req0_e;
    logic              req1_e;
    logic [1:0]        gnt;
    logic              any_gnt;
    logic              sel1;
    logic              we;
    logic              timeout;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

`ifdef DRAM_ARB_RR_EN
    assign rr_en = 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst)        last <= 1'b1;
        else if (any_gnt) last <= sel1;
    end
`else
    assign rr_en = 1'b0;
    assign last  = 1'b1;
`endif

    // Reset and the foreign port during a lock both mask requests.
    always_comb begin
        req0_e = 1'b0;
        req1_e = 1'b0;
        if (!i_rst) begin
            req0_e = i_p0_req && (state != LOCK1);
            req1_e = i_p1_req && (state != LOCK0);
        end
    end

    dram_arb_pick u_pick (
        .req0  (req0_e),
        .req1  (req1_e),
        .last  (last),
        .rr_en (rr_en),
        .gnt   (gnt)
    );

    assign o_p0_gnt = gnt[P0];
    assign o_p1_gnt = gnt[P1];
    assign any_gnt  = |gnt;
    assign sel1     = gnt[P1];
    assign we       = sel1 ? i_p1_we    : i_p0_we;
    assign addr     = sel1 ? i_p1_addr  : i_p0_addr;
    assign wdata    = sel1 ? i_p1_wdata : i_p0_wdata;

    assign o_ram_write      = any_gnt && we;
    assign o_ram_read       = any_gnt && !we;
    assign o_ram_addr_write = o_ram_write ? addr  : '0;
    assign o_ram_data_write = o_ram_write ? wdata : '0;
    assign o_ram_addr_read  = o_ram_read  ? addr  : '0;

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt[P0] && i_p0_lock)      state_nxt = LOCK0;
                else if (gnt[P1] && i_p1_lock) state_nxt = LOCK1;
            end
            LOCK0: begin
                if (cnt == LOCK_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end else if (!i_p0_lock && (gnt[P0] || !i_p0_req)) begin
                    state_nxt = IDLE;
                end
            end
            LOCK1: begin
                if (cnt == LOCK_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end else if (!i_p1_lock && (gnt[P1] || !i_p1_req)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            o_lock_err  <= 1'b0;
            o_p0_rvalid <= 1'b0;
            o_p1_rvalid <= 1'b0;
            o_p0_rdata  <= '0;
            o_p1_rdata  <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= (state == IDLE) ? 4'd0 : cnt + 4'd1;
            o_lock_err  <= timeout;
            o_p0_rvalid <= gnt[P0] && !i_p0_we;
            o_p1_rvalid <= gnt[P1] && !i_p1_we;
            if (gnt[P0] && !i_p0_we) o_p0_rdata <= i_ram_data_read;
            if (gnt[P1] && !i_p1_we) o_p1_rdata <= i_ram_data_read;
        end
    end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: directed bench for data_ram_arbiter with a 256x16 RAM model.
// Tie expectations follow DRAM_ARB_RR_EN.
module tb_data_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_lock;
    logic [7:0]  p0_addr;
    logic [15:0] p0_wdata;
    logic        p1_req, p1_we, p1_lock;
    logic [7:0]  p1_addr;
    logic [15:0] p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, lock_err;
    logic [15:0] p0_rdata, p1_rdata;
    logic        ram_write, ram_read;
    logic [7:0]  ram_addr_write, ram_addr_read;
    logic [15:0] ram_data_write, ram_data_read;

    logic [15:0] mem [256];
    logic        mem_ok = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_ram_arbiter dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_p0_req         (p0_req),
        .i_p0_we          (p0_we),
        .i_p0_addr        (p0_addr),
        .i_p0_wdata       (p0_wdata),
        .i_p0_lock        (p0_lock),
        .o_p0_gnt         (p0_gnt),
        .o_p0_rvalid      (p0_rvalid),
        .o_p0_rdata       (p0_rdata),
        .i_p1_req         (p1_req),
        .i_p1_we          (p1_we),
        .i_p1_addr        (p1_addr),
        .i_p1_wdata       (p1_wdata),
        .i_p1_lock        (p1_lock),
        .o_p1_gnt         (p1_gnt),
        .o_p1_rvalid      (p1_rvalid),
        .o_p1_rdata       (p1_rdata),
        .o_lock_err       (lock_err),
        .o_ram_write      (ram_write),
        .o_ram_addr_write (ram_addr_write),
        .o_ram_data_write (ram_data_write),
        .o_ram_read       (ram_read),
        .o_ram_addr_read  (ram_addr_read),
        .i_ram_data_read  (ram_data_read)
    );

    // Preload mem[a] = 0xA000 + a on the first edge.
    always @(posedge clk) begin
        if (!mem_ok) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
            mem_ok <= 1'b1;
        end else if (ram_write) begin
            mem[ram_addr_write] <= ram_data_write;
        end
    end

    assign ram_data_read = mem[ram_addr_read];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic rd0(input logic [7:0] a, input logic lk);
        p0_req = 1; p0_we = 0; p0_addr = a; p0_lock = lk;
    endtask

    task automatic rd1(input logic [7:0] a, input logic lk);
        p1_req = 1; p1_we = 0; p1_addr = a; p1_lock = lk;
    endtask

    initial begin
        rst = 1;
        clr();
        p0_req = 1; p0_we = 1; p0_addr = 8'h55; p0_wdata = 16'h1111;
        tick();
        @(negedge clk);
        check("rst_gnt0", p0_gnt, 0);
        check("rst_wr",   ram_write, 0);
        check("rst_awr",  ram_addr_write, 0);
        check("rst_rv0",  p0_rvalid, 0);
        check("rst_rd0",  p0_rdata, 0);
        check("rst_lerr", lock_err, 0);
        tick();
        rst = 0;

        // write then read-after-write on the other port
        clr();
        p0_req = 1; p0_we = 1; p0_addr = 8'h10; p0_wdata = 16'hBEEF;
        @(negedge clk);
        check("wr_gnt0", p0_gnt, 1);
        check("wr_str",  ram_write, 1);
        check("wr_addr", ram_addr_write, 8'h10);
        check("wr_data", ram_data_write, 16'hBEEF);
        check("wr_nord", ram_read, 0);
        tick();
        clr();
        rd1(8'h10, 0);
        @(negedge clk);
        check("rd_gnt1", p1_gnt, 1);
        check("rd_str",  ram_read, 1);
        check("rd_addr", ram_addr_read, 8'h10);
        tick();
        clr();
        @(negedge clk);
        check("rd_rv1", p1_rvalid, 1);
        check("rd_rd1", p1_rdata, 16'hBEEF);
        tick();
        @(negedge clk);
        check("rd_rv1_off", p1_rvalid, 0);
        check("rd_rd1_hold", p1_rdata, 16'hBEEF);
        tick();

        // both requesting for four cycles
        clr();
        rd0(8'h01, 0);
        rd1(8'h02, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef DRAM_ARB_RR_EN
            check("tie_g0", p0_gnt, (i % 2 == 0));
            check("tie_g1", p1_gnt, (i % 2 == 1));
`else
            check("tie_g0", p0_gnt, 1);
            check("tie_g1", p1_gnt, 0);
`endif
            tick();
        end
        clr();
        @(negedge clk);
`ifdef DRAM_ARB_RR_EN
        check("tie_rv1", p1_rvalid, 1);
        check("tie_rd1", p1_rdata, 16'hA002);
        check("tie_rd0", p0_rdata, 16'hA001);
`else
        check("tie_rv0", p0_rvalid, 1);
        check("tie_rd0", p0_rdata, 16'hA001);
        check("tie_rd1", p1_rdata, 16'hBEEF);
`endif
        tick();

        // port 1 read-modify-write under lock
        clr();
        rd1(8'h20, 1);
        @(negedge clk);
        check("lk_g1", p1_gnt, 1);
        tick();
        clr();
        p1_lock = 1;
        rd0(8'h05, 0);
        @(negedge clk);
        check("lk_g0_blk", p0_gnt, 0);
        check("lk_no_rd",  ram_read, 0);
        check("lk_rv1",    p1_rvalid, 1);
        check("lk_rd1",    p1_rdata, 16'hA020);
        tick();
        p1_req = 1; p1_we = 1; p1_addr = 8'h20; p1_wdata = 16'h1234; p1_lock = 0;
        @(negedge clk);
        check("lk_wr_g1", p1_gnt, 1);
        check("lk_wr_g0", p0_gnt, 0);
        check("lk_wr_d",  ram_data_write, 16'h1234);
        tick();
        p1_req = 0; p1_we = 0;
        @(negedge clk);
        check("lk_after_g0", p0_gnt, 1);
        check("lk_after_a",  ram_addr_read, 8'h05);
        tick();
        clr();
        @(negedge clk);
        check("lk_rv0", p0_rvalid, 1);
        check("lk_rd0", p0_rdata, 16'hA005);
        tick();

        // lock held idle until forced release
        clr();
        rd0(8'h30, 1);
        @(negedge clk);
        check("to_g0", p0_gnt, 1);
        tick();
        clr();
        p0_lock = 1;
        rd1(8'h07, 0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("to_hold_g1", p1_gnt, 0);
            check("to_hold_err", lock_err, 0);
            tick();
        end
        @(negedge clk);
        check("to_err", lock_err, 1);
        check("to_g1",  p1_gnt, 1);
        tick();
        clr();
        @(negedge clk);
        check("to_err_off", lock_err, 0);
        check("to_rv1", p1_rvalid, 1);
        check("to_rd1", p1_rdata, 16'hA007);
        tick();

        // reset in LOCK0 with a write pending
        clr();
        rd0(8'h40, 1);
        @(negedge clk);
        check("rs_g0", p0_gnt, 1);
        tick();
        rst = 1;
        p0_req = 1; p0_we = 1; p0_addr = 8'h40; p0_wdata = 16'hDEAD; p0_lock = 1;
        @(negedge clk);
        check("rs_gnt0", p0_gnt, 0);
        check("rs_wr",   ram_write, 0);
        check("rs_awr",  ram_addr_write, 0);
        check("rs_dwr",  ram_data_write, 0);
        tick();
        rst = 0;
        clr();
        rd1(8'h40, 0);
        @(negedge clk);
        check("rs_g1",  p1_gnt, 1);
        check("rs_rv0", p0_rvalid, 0);
        check("rs_rd0", p0_rdata, 0);
        tick();
        clr();
        @(negedge clk);
        check("rs_rd1", p1_rdata, 16'hA040);
        tick();

        // back-to-back reads on port 0
        for (int i = 0; i < 4; i++) begin
            clr();
            rd0(8'(i), 0);
            @(negedge clk);
            check("bb_g0", p0_gnt, 1);
            if (i > 0) begin
                check("bb_rv0", p0_rvalid, 1);
                check("bb_rd0", p0_rdata, 32'hA000 + i - 1);
            end
            tick();
        end
        clr();
        @(negedge clk);
        check("bb_rv0_last", p0_rvalid, 1);
        check("bb_rd0_last", p0_rdata, 16'hA003);
        tick();
        @(negedge clk);
        check("bb_rv0_off", p0_rvalid, 0);
        tick();

        // locked write landed in RAM
        rd0(8'h20, 0);
        tick();
        clr();
        @(negedge clk);
        check("rmw_rd0", p0_rdata, 16'h1234);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
